// File: rtl/hdmi_video_scheduler_if.sv
// Upstream frame-FIFO pixel stream: 24b {R,G,B} pixel plus start-of-frame marker, valid/ready handshake.
interface hdmi_video_scheduler_if;
    logic [23:0] in_pixel;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_pixel, output in_sof, output in_valid, input in_ready);
    modport slave  (input in_pixel, input in_sof, input in_valid, output in_ready);
endinterface

// File: rtl/hdmi_video_scheduler.sv
// Raster timing generator and pixel scheduler for the HDMI transmitter: free-running h/v counters,
// registered syncs/de, and a frame-locking pull from the upstream stream with blank-and-resync on errors.
module hdmi_video_scheduler #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    hdmi_video_scheduler_if.slave        stream,
    output logic [23:0]                  pixel_data,
    output logic                         pixel_valid,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         frame_start,
    output logic                         underflow,
    output logic                         sof_err,
    output logic [15:0]                  err_cnt
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, FLUSH} state_t;

    state_t        state;
    state_t        eff_state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          origin;
    logic          hsync_on;
    logic          vsync_on;
    logic          lock;
    logic          run_ok;
    logic          run_uf;
    logic          run_se;
    logic          ready;

    // A FLUSH that reaches the frame origin behaves as WAIT_SOF in that same cycle so it can relock at once.
    always_comb begin
        active    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        origin    = (h_cnt == '0) && (v_cnt == '0);
        hsync_on  = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
        vsync_on  = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
        eff_state = (state == FLUSH && origin) ? WAIT_SOF : state;
        lock      = (eff_state == WAIT_SOF) && origin && stream.in_valid && stream.in_sof;
        run_uf    = (eff_state == RUN) && active && !stream.in_valid;
        run_se    = (eff_state == RUN) && active && stream.in_valid && (stream.in_sof != origin);
        run_ok    = (eff_state == RUN) && active && stream.in_valid && (stream.in_sof == origin);
        ready     = 1'b0;
        if (enable) begin
            case (eff_state)
                WAIT_SOF: ready = lock || (stream.in_valid && !stream.in_sof);
                RUN:      ready = run_ok;
                default:  ready = 1'b0;
            endcase
        end
    end

    assign stream.in_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sof_err     <= 1'b0;
            err_cnt     <= '0;
        end else if (!enable || state == IDLE) begin
            // Idle or being disabled: park at the origin with quiet outputs; the error count survives.
            state       <= enable ? WAIT_SOF : IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sof_err     <= 1'b0;
        end else begin
            if (int'(h_cnt) == H_TOT - 1) begin
                h_cnt <= '0;
                v_cnt <= (int'(v_cnt) == V_TOT - 1) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            pixel_valid <= active;
            hsync       <= hsync_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vsync_on ? SYNC_POL : ~SYNC_POL;
            pixel_data  <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sof_err     <= 1'b0;
            case (eff_state)
                WAIT_SOF: begin
                    state <= WAIT_SOF;
                    if (lock) begin
                        pixel_data  <= stream.in_pixel;
                        frame_start <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (run_uf) begin
                        underflow <= 1'b1;
                        state     <= FLUSH;
                    end else if (run_se) begin
                        sof_err <= 1'b1;
                        state   <= FLUSH;
                    end else if (run_ok) begin
                        pixel_data  <= stream.in_pixel;
                        frame_start <= origin;
                    end
                end
                default: state <= FLUSH;
            endcase
            if ((run_uf || run_se) && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_video_scheduler.sv
// Self-checking bench for hdmi_video_scheduler on a tiny 8x6 raster, compared every cycle against
// a frame-position model driven by a queue of upstream pixels.
module tb_hdmi_video_scheduler;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam bit POL = 1'b1;

    typedef struct {
        logic        sof;
        logic [23:0] pix;
    } beat_t;

    typedef enum {M_IDLE, M_HUNT, M_RUN, M_FLUSH} mode_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        underflow;
    logic        sof_err;
    logic [15:0] err_cnt;

    hdmi_video_scheduler_if stream_if ();

    hdmi_video_scheduler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .stream(stream_if),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start),
        .underflow(underflow),
        .sof_err(sof_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    beat_t       q[$];
    logic        gap = 1'b0;
    int          n_checks = 0;
    int          n_fails = 0;
    mode_t       mode = M_IDLE;
    int          t = 0;
    int          m_err = 0;
    logic        m_ready;
    logic [23:0] exp_data;
    logic        exp_de, exp_hs, exp_vs, exp_fs, exp_uf, exp_se;
    logic [15:0] exp_err;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_exp_reset();
        exp_data = 24'h0;
        exp_de   = 1'b0;
        exp_hs   = ~POL;
        exp_vs   = ~POL;
        exp_fs   = 1'b0;
        exp_uf   = 1'b0;
        exp_se   = 1'b0;
        exp_err  = 16'(m_err);
    endtask

    // Frame position is derived from elapsed cycles since enable; lock state follows the stream rules.
    task automatic model_cycle();
        int          h, v;
        bit          act, org;
        logic        valid, sof;
        logic [23:0] pix;
        valid   = stream_if.in_valid;
        sof     = stream_if.in_sof;
        pix     = stream_if.in_pixel;
        m_ready = 1'b0;
        if (!enable) begin
            mode = M_IDLE;
            t    = 0;
            set_exp_reset();
        end else if (mode == M_IDLE) begin
            mode = M_HUNT;
            t    = 0;
            set_exp_reset();
        end else begin
            h   = t % HT;
            v   = (t / HT) % VT;
            act = (h < HA) && (v < VA);
            org = (t % FT) == 0;
            if (mode == M_FLUSH && org) mode = M_HUNT;
            exp_de   = act;
            exp_hs   = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
            exp_vs   = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
            exp_data = 24'h0;
            exp_fs   = 1'b0;
            exp_uf   = 1'b0;
            exp_se   = 1'b0;
            if (mode == M_HUNT) begin
                if (org && valid && sof) begin
                    m_ready  = 1'b1;
                    exp_data = pix;
                    exp_fs   = 1'b1;
                    mode     = M_RUN;
                end else begin
                    m_ready = valid && !sof;
                end
            end else if (mode == M_RUN && act) begin
                if (!valid) begin
                    exp_uf = 1'b1;
                    mode   = M_FLUSH;
                end else if (sof != org) begin
                    exp_se = 1'b1;
                    mode   = M_FLUSH;
                end else begin
                    m_ready  = 1'b1;
                    exp_data = pix;
                    exp_fs   = org;
                end
            end
            if ((exp_uf || exp_se) && m_err < 65535) m_err++;
            exp_err = 16'(m_err);
            t++;
        end
    endtask

    task automatic check_output();
        check_value("pixel_data", 32'(pixel_data), 32'(exp_data));
        check_value("pixel_valid", 32'(pixel_valid), 32'(exp_de));
        check_value("hsync", 32'(hsync), 32'(exp_hs));
        check_value("vsync", 32'(vsync), 32'(exp_vs));
        check_value("frame_start", 32'(frame_start), 32'(exp_fs));
        check_value("underflow", 32'(underflow), 32'(exp_uf));
        check_value("sof_err", 32'(sof_err), 32'(exp_se));
        check_value("err_cnt", 32'(err_cnt), 32'(exp_err));
    endtask

    // One pixel clock: present the queue head, check the handshake, then the registered outputs.
    task automatic apply_stimulus();
        stream_if.in_valid = (q.size() > 0) && !gap;
        stream_if.in_pixel = (q.size() > 0) ? q[0].pix : 24'h0;
        stream_if.in_sof   = (q.size() > 0) ? q[0].sof : 1'b0;
        #1;
        model_cycle();
        check_value("in_ready", 32'(stream_if.in_ready), 32'(m_ready));
        if (m_ready && stream_if.in_valid) void'(q.pop_front());
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic push_beat(input logic sof, input logic [23:0] pix);
        beat_t b;
        b.sof = sof;
        b.pix = pix;
        q.push_back(b);
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) push_beat(i == 0, 24'($urandom));
    endtask

    initial begin
        stream_if.in_valid = 1'b0;
        stream_if.in_pixel = 24'h0;
        stream_if.in_sof   = 1'b0;
        #2;
        set_exp_reset();
        check_output();
        check_value("in_ready_reset", 32'(stream_if.in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] free-running raster with no input");
        enable = 1'b1;
        run_cycles(FT + 8);

        $display("[TB] lock on counting frame, then a random frame");
        for (int i = 1; i <= 12; i++) push_beat(i == 1, 24'(i));
        push_frame(12);
        run_cycles(2 * FT + 8);

        $display("[TB] heads without sof are dropped");
        for (int i = 0; i < 3; i++) push_beat(1'b0, 24'($urandom));
        push_frame(12);
        run_cycles(2 * FT);

        $display("[TB] underflow at line 1 pixel 2");
        q.delete();
        push_frame(6);
        run_cycles(FT);
        push_frame(12);
        run_cycles(2 * FT);

        $display("[TB] misaligned sof on pixel 5");
        q.delete();
        push_frame(4);
        push_frame(12);
        run_cycles(3 * FT);

        $display("[TB] random gaps and sof placement");
        for (int i = 0; i < 3 * FT; i++) begin
            gap = ($urandom_range(0, 5) == 0);
            if (q.size() < 4) push_beat($urandom_range(0, 11) == 0, 24'($urandom));
            apply_stimulus();
        end
        gap = 1'b0;

        $display("[TB] disable mid-line and re-enable");
        q.delete();
        push_frame(12);
        for (int i = 0; i < 2 * HT && (t % HT) != 2; i++) apply_stimulus();
        enable = 1'b0;
        run_cycles(3);
        enable = 1'b1;
        push_frame(12);
        run_cycles(2 * FT);

        $display("[TB] asynchronous reset mid-frame");
        run_cycles(13);
        #3;
        rst_n = 1'b0;
        #1;
        mode  = M_IDLE;
        t     = 0;
        m_err = 0;
        set_exp_reset();
        check_output();
        check_value("in_ready_async_reset", 32'(stream_if.in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        push_frame(12);
        run_cycles(FT + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
